// File: rtl/simple_arb_pkg.sv
// Shared definitions for the simple_rw_arbiter slice: FSM state encodings,
// round-robin grant identifiers and the even-parity helper.
package simple_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR      = 3'd1;
  localparam state_t ST_RD_REQ  = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_RD_RESP = 3'd4;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  // Widest field the parity helper accepts; callers zero-extend into it.
  localparam int PAR_MAX_W = 256;

  // Even parity of a field: XOR of all bits (zero padding does not change it).
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/simple_arb_parity_chk.sv
// Parity checker for accepted beats of simple_rw_arbiter. Flags a beat as
// errored on a parity mismatch or when fault injection is active, and keeps
// a sticky error flag that a set request wins over a simultaneous clear.
// Only instantiated when SIMPLE_ARB_PARITY_CHK_EN is defined.
module simple_arb_parity_chk
  import simple_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_accept,
  input  logic              rd_accept,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              waddr_parity,
  input  logic              wdata_parity,
  input  logic              raddr_parity,
  input  logic              enerr,
  input  logic              fierr,
  input  logic              err_clr,
  output logic              beat_err,
  output logic              err,
  output logic              err_b
);

  logic wr_mismatch_s;
  logic rd_mismatch_s;
  logic err_r;

  // Compare received parity bits against the recomputed field parity.
  always_comb begin
    wr_mismatch_s = (even_parity(PAR_MAX_W'(waddr)) != waddr_parity) |
                    (even_parity(PAR_MAX_W'(wdata)) != wdata_parity);
    rd_mismatch_s = (even_parity(PAR_MAX_W'(raddr)) != raddr_parity);
    beat_err      = (wr_accept & (wr_mismatch_s | fierr)) |
                    (rd_accept & (rd_mismatch_s | fierr));
  end

  // Sticky error flag: set on a reported beat error, cleared by err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (beat_err && enerr) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign err   = err_r;
  assign err_b = ~err_r;

endmodule

// File: rtl/simple_rw_arbiter.sv
// simple_rw_arbiter: shares a single-port memory between a write channel and
// a read channel with round-robin arbitration, sequences memory request,
// read latency and response, and counts completed transactions on STATUS.
// Optional beat parity checking is built when SIMPLE_ARB_PARITY_CHK_EN is
// defined; otherwise parity inputs are ignored and error outputs are idle.
module simple_rw_arbiter
  import simple_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              ACLK,
  input  logic              RESETN_ACLK,
  input  logic              WADDR_VALID,
  input  logic [ADDR_W-1:0] WADDR_DATA,
  output logic              WADDR_READY,
  input  logic              WDATA_VALID,
  input  logic [DATA_W-1:0] WDATA_DATA,
  output logic              WDATA_READY,
  input  logic              RADDR_VALID,
  input  logic [ADDR_W-1:0] RADDR_DATA,
  output logic              RADDR_READY,
  output logic              RDATA_VALID,
  output logic [DATA_W-1:0] RDATA_DATA,
  input  logic              RDATA_READY,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [7:0]        STATUS,
  input  logic              WADDR_PARITY,
  input  logic              WDATA_PARITY,
  input  logic              RADDR_PARITY,
  input  logic              ENERR_PARITY,
  input  logic              FIERR_PARITY,
  input  logic              ERR_CLR,
  output logic              ERR_PARITY,
  output logic              ERR_PARITY_B,
  output logic              RDATA_PARITY
);

  localparam logic [2:0] LAT_C = 3'(MEM_LAT);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              last_grant_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [2:0]        wait_cnt_r;
  logic [7:0]        status_r;
  logic              rd_err_r;

  logic wr_cand_s;
  logic rd_cand_s;
  logic grant_wr_s;
  logic grant_rd_s;
  logic rd_done_s;
  logic rd_hs_s;
  logic beat_err_s;

  // Round-robin grant in IDLE; a write needs both address and data valid.
  always_comb begin
    wr_cand_s = (state_r == ST_IDLE) & WADDR_VALID & WDATA_VALID;
    rd_cand_s = (state_r == ST_IDLE) & RADDR_VALID;
    if (wr_cand_s && rd_cand_s) begin
      grant_wr_s = (last_grant_r == GRANT_RD);
      grant_rd_s = (last_grant_r == GRANT_WR);
    end else begin
      grant_wr_s = wr_cand_s;
      grant_rd_s = rd_cand_s;
    end
    rd_done_s = (state_r == ST_RD_WAIT) && (wait_cnt_r == LAT_C);
    rd_hs_s   = (state_r == ST_RD_RESP) && RDATA_READY;
  end

  // Next-state decode; errored beats skip the memory access.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_wr_s) begin
          state_nxt_s = beat_err_s ? ST_IDLE : ST_WR;
        end else if (grant_rd_s) begin
          state_nxt_s = beat_err_s ? ST_RD_RESP : ST_RD_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR:      state_nxt_s = ST_IDLE;
      ST_RD_REQ:  state_nxt_s = ST_RD_WAIT;
      ST_RD_WAIT: state_nxt_s = rd_done_s ? ST_RD_RESP : ST_RD_WAIT;
      ST_RD_RESP: state_nxt_s = RDATA_READY ? ST_IDLE : ST_RD_RESP;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge ACLK) begin
    if (!RESETN_ACLK) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the granted address/data and remember who was served last.
  always_ff @(posedge ACLK) begin
    if (!RESETN_ACLK) begin
      last_grant_r <= GRANT_RD;
      addr_r       <= '0;
      wdata_r      <= '0;
    end else if (grant_wr_s) begin
      last_grant_r <= GRANT_WR;
      addr_r       <= WADDR_DATA;
      wdata_r      <= WDATA_DATA;
    end else if (grant_rd_s) begin
      last_grant_r <= GRANT_RD;
      addr_r       <= RADDR_DATA;
      wdata_r      <= wdata_r;
    end else begin
      last_grant_r <= last_grant_r;
      addr_r       <= addr_r;
      wdata_r      <= wdata_r;
    end
  end

  // Count read latency cycles; the first RD_WAIT cycle is count 1.
  always_ff @(posedge ACLK) begin
    if (!RESETN_ACLK) begin
      wait_cnt_r <= 3'd0;
    end else if (state_r == ST_RD_REQ) begin
      wait_cnt_r <= 3'd1;
    end else if (state_r == ST_RD_WAIT) begin
      wait_cnt_r <= wait_cnt_r + 3'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Read response register: memory data when latency expires, zero on an errored read.
  always_ff @(posedge ACLK) begin
    if (!RESETN_ACLK) begin
      rdata_r  <= '0;
      rd_err_r <= 1'b0;
    end else if (grant_rd_s) begin
      rdata_r  <= beat_err_s ? '0 : rdata_r;
      rd_err_r <= beat_err_s;
    end else if (rd_done_s) begin
      rdata_r  <= MEM_RDATA;
      rd_err_r <= rd_err_r;
    end else begin
      rdata_r  <= rdata_r;
      rd_err_r <= rd_err_r;
    end
  end

  // Completed-transaction counter: memory writes and good read handshakes.
  always_ff @(posedge ACLK) begin
    if (!RESETN_ACLK) begin
      status_r <= 8'd0;
    end else if ((state_r == ST_WR) || (rd_hs_s && !rd_err_r)) begin
      status_r <= status_r + 8'd1;
    end else begin
      status_r <= status_r;
    end
  end

  assign WADDR_READY = grant_wr_s;
  assign WDATA_READY = grant_wr_s;
  assign RADDR_READY = grant_rd_s;
  assign RDATA_VALID = (state_r == ST_RD_RESP);
  assign RDATA_DATA  = rdata_r;
  assign MEM_REQ     = (state_r == ST_WR) || (state_r == ST_RD_REQ);
  assign MEM_WE      = (state_r == ST_WR);
  assign MEM_ADDR    = addr_r;
  assign MEM_WDATA   = wdata_r;
  assign STATUS      = status_r;

`ifdef SIMPLE_ARB_PARITY_CHK_EN
  simple_arb_parity_chk #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_parity_chk (
    .clk          (ACLK),
    .rst_n        (RESETN_ACLK),
    .wr_accept    (grant_wr_s),
    .rd_accept    (grant_rd_s),
    .waddr        (WADDR_DATA),
    .wdata        (WDATA_DATA),
    .raddr        (RADDR_DATA),
    .waddr_parity (WADDR_PARITY),
    .wdata_parity (WDATA_PARITY),
    .raddr_parity (RADDR_PARITY),
    .enerr        (ENERR_PARITY),
    .fierr        (FIERR_PARITY),
    .err_clr      (ERR_CLR),
    .beat_err     (beat_err_s),
    .err          (ERR_PARITY),
    .err_b        (ERR_PARITY_B)
  );

  assign RDATA_PARITY = even_parity(PAR_MAX_W'(rdata_r));
`else
  logic unused_parity_s;

  assign unused_parity_s = ^{WADDR_PARITY, WDATA_PARITY, RADDR_PARITY,
                             ENERR_PARITY, FIERR_PARITY, ERR_CLR};
  assign beat_err_s      = 1'b0;
  assign ERR_PARITY      = 1'b0;
  assign ERR_PARITY_B    = 1'b1;
  assign RDATA_PARITY    = 1'b0;
`endif

endmodule

// File: tb/tb_simple_rw_arbiter.sv
// Directed self-checking bench for simple_rw_arbiter with a latency-1 memory model.
module tb_simple_rw_arbiter;

  logic        ACLK = 1'b0;
  logic        RESETN_ACLK;
  logic        WADDR_VALID, WDATA_VALID, RADDR_VALID, RDATA_READY;
  logic [31:0] WADDR_DATA, RADDR_DATA;
  logic [63:0] WDATA_DATA;
  logic        WADDR_READY, WDATA_READY, RADDR_READY, RDATA_VALID;
  logic [63:0] RDATA_DATA;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [63:0] MEM_WDATA, MEM_RDATA;
  logic [7:0]  STATUS;
  logic        WADDR_PARITY, WDATA_PARITY, RADDR_PARITY;
  logic        ENERR_PARITY, FIERR_PARITY, ERR_CLR;
  logic        ERR_PARITY, ERR_PARITY_B, RDATA_PARITY;
  logic        waddr_flip;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_status;
  logic [63:0] mem [0:255];

  simple_rw_arbiter dut (
    .ACLK(ACLK), .RESETN_ACLK(RESETN_ACLK),
    .WADDR_VALID(WADDR_VALID), .WADDR_DATA(WADDR_DATA), .WADDR_READY(WADDR_READY),
    .WDATA_VALID(WDATA_VALID), .WDATA_DATA(WDATA_DATA), .WDATA_READY(WDATA_READY),
    .RADDR_VALID(RADDR_VALID), .RADDR_DATA(RADDR_DATA), .RADDR_READY(RADDR_READY),
    .RDATA_VALID(RDATA_VALID), .RDATA_DATA(RDATA_DATA), .RDATA_READY(RDATA_READY),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .STATUS(STATUS),
    .WADDR_PARITY(WADDR_PARITY), .WDATA_PARITY(WDATA_PARITY), .RADDR_PARITY(RADDR_PARITY),
    .ENERR_PARITY(ENERR_PARITY), .FIERR_PARITY(FIERR_PARITY), .ERR_CLR(ERR_CLR),
    .ERR_PARITY(ERR_PARITY), .ERR_PARITY_B(ERR_PARITY_B), .RDATA_PARITY(RDATA_PARITY)
  );

  always #5 ACLK = ~ACLK;

  assign WADDR_PARITY = (^WADDR_DATA) ^ waddr_flip;
  assign WDATA_PARITY = ^WDATA_DATA;
  assign RADDR_PARITY = ^RADDR_DATA;

  // Single-port memory model: writes on MEM_REQ&WE, read data valid one cycle after MEM_REQ.
  always @(posedge ACLK) begin
    if (MEM_REQ && MEM_WE) mem[MEM_ADDR[7:0]] <= MEM_WDATA;
    if (MEM_REQ && !MEM_WE) MEM_RDATA <= mem[MEM_ADDR[7:0]];
    else MEM_RDATA <= 64'hBAD0_BAD0_BAD0_BAD0;
  end

  task automatic step();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    WADDR_VALID = 1'b0; WDATA_VALID = 1'b0; RADDR_VALID = 1'b0; RDATA_READY = 1'b0;
    WADDR_DATA = 32'h0; WDATA_DATA = 64'h0; RADDR_DATA = 32'h0;
    ENERR_PARITY = 1'b0; FIERR_PARITY = 1'b0; ERR_CLR = 1'b0; waddr_flip = 1'b0;
    RESETN_ACLK = 1'b0;
    step(); step();
    RESETN_ACLK = 1'b1;
    #1;
    n_checks++;
    if ({WADDR_READY, WDATA_READY, RADDR_READY, RDATA_VALID, MEM_REQ, MEM_WE} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
        {WADDR_READY, WDATA_READY, RADDR_READY, RDATA_VALID, MEM_REQ, MEM_WE});
    end
    n_checks++;
    if (RDATA_DATA !== 64'h0 || STATUS !== 8'h00 || MEM_ADDR !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: rdata %h status %h addr %h want zeros", RDATA_DATA, STATUS, MEM_ADDR);
    end
    n_checks++;
    if (ERR_PARITY !== 1'b0 || ERR_PARITY_B !== 1'b1) begin
      n_fail++; $display("FAIL reset_err: err %b err_b %b want 0 1", ERR_PARITY, ERR_PARITY_B);
    end
    exp_status = 8'h00;
  endtask

  task automatic test_write(input logic [31:0] a, input logic [63:0] d);
    WADDR_VALID = 1'b1; WDATA_VALID = 1'b1; WADDR_DATA = a; WDATA_DATA = d;
    #1;
    n_checks++;
    if (WADDR_READY !== 1'b1 || WDATA_READY !== 1'b1 || RADDR_READY !== 1'b0) begin
      n_fail++; $display("FAIL wr_accept: readys %b%b%b want 110", WADDR_READY, WDATA_READY, RADDR_READY);
    end
    step();
    WADDR_VALID = 1'b0; WDATA_VALID = 1'b0;
    #1;
    n_checks++;
    if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || MEM_ADDR !== a || MEM_WDATA !== d) begin
      n_fail++; $display("FAIL wr_mem: req %b we %b addr %h wdata %h want 1 1 %h %h",
        MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, a, d);
    end
    step();
    exp_status = exp_status + 8'd1;
    n_checks++;
    if (STATUS !== exp_status || MEM_REQ !== 1'b0) begin
      n_fail++; $display("FAIL wr_status: status %h req %b want %h 0", STATUS, MEM_REQ, exp_status);
    end
  endtask

  task automatic test_read(input logic [31:0] a, input logic [63:0] d, input int hold);
    logic exp_par;
`ifdef SIMPLE_ARB_PARITY_CHK_EN
    exp_par = ^d;
`else
    exp_par = 1'b0;
`endif
    RADDR_VALID = 1'b1; RADDR_DATA = a; RDATA_READY = 1'b0;
    #1;
    n_checks++;
    if (RADDR_READY !== 1'b1 || WADDR_READY !== 1'b0) begin
      n_fail++; $display("FAIL rd_accept: rready %b wready %b want 1 0", RADDR_READY, WADDR_READY);
    end
    step();
    RADDR_VALID = 1'b0;
    #1;
    n_checks++;
    if (MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== a || RDATA_VALID !== 1'b0) begin
      n_fail++; $display("FAIL rd_req: req %b we %b addr %h rvalid %b want 1 0 %h 0",
        MEM_REQ, MEM_WE, MEM_ADDR, RDATA_VALID, a);
    end
    step();
    n_checks++;
    if (RDATA_VALID !== 1'b0 || MEM_REQ !== 1'b0) begin
      n_fail++; $display("FAIL rd_wait: rvalid %b req %b want 0 0", RDATA_VALID, MEM_REQ);
    end
    step();
    for (int i = 0; i < hold; i++) begin
      n_checks++;
      if (RDATA_VALID !== 1'b1 || RDATA_DATA !== d || STATUS !== exp_status || RDATA_PARITY !== exp_par) begin
        n_fail++; $display("FAIL rd_hold%0d: rvalid %b rdata %h status %h par %b want 1 %h %h %b",
          i, RDATA_VALID, RDATA_DATA, STATUS, RDATA_PARITY, d, exp_status, exp_par);
      end
      if (i < hold - 1) step();
    end
    RDATA_READY = 1'b1;
    step();
    RDATA_READY = 1'b0;
    exp_status = exp_status + 8'd1;
    n_checks++;
    if (RDATA_VALID !== 1'b0 || STATUS !== exp_status) begin
      n_fail++; $display("FAIL rd_done: rvalid %b status %h want 0 %h", RDATA_VALID, STATUS, exp_status);
    end
  endtask

  task automatic test_alternate();
    logic exp_wr;
    int   waited;
    RESETN_ACLK = 1'b0;
    step();
    RESETN_ACLK = 1'b1;
    exp_status = 8'h00;
    WADDR_VALID = 1'b1; WDATA_VALID = 1'b1; WADDR_DATA = 32'h30; WDATA_DATA = 64'h3333;
    RADDR_VALID = 1'b1; RADDR_DATA = 32'h30; RDATA_READY = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_wr = ((g % 2) == 0);
      waited = 0;
      #1;
      while (!(WADDR_READY || RADDR_READY) && waited < 10) begin
        step(); #1; waited++;
      end
      n_checks++;
      if (waited >= 10) begin
        n_fail++; $display("FAIL alt_grant%0d: no grant within 10 cycles", g);
      end else if (WADDR_READY !== exp_wr || RADDR_READY !== !exp_wr) begin
        n_fail++; $display("FAIL alt_grant%0d: wready %b rready %b want %b %b",
          g, WADDR_READY, RADDR_READY, exp_wr, !exp_wr);
      end
      step();
    end
    WADDR_VALID = 1'b0; WDATA_VALID = 1'b0; RADDR_VALID = 1'b0;
    step(); step(); step(); step();
    RDATA_READY = 1'b0;
    exp_status = 8'd4;
    n_checks++;
    if (STATUS !== exp_status || RDATA_VALID !== 1'b0) begin
      n_fail++; $display("FAIL alt_status: status %h rvalid %b want 04 0", STATUS, RDATA_VALID);
    end
  endtask

  task automatic test_wr_incomplete();
    WADDR_VALID = 1'b1; WDATA_VALID = 1'b0; WADDR_DATA = 32'h44;
    #1;
    n_checks++;
    if (WADDR_READY !== 1'b0 || WDATA_READY !== 1'b0) begin
      n_fail++; $display("FAIL half_wr_grant: wready %b dready %b want 0 0", WADDR_READY, WDATA_READY);
    end
    step();
    n_checks++;
    if (MEM_REQ !== 1'b0) begin
      n_fail++; $display("FAIL half_wr_req: req %b want 0", MEM_REQ);
    end
    WADDR_VALID = 1'b0;
    test_read(32'h10, 64'hA5A5, 1);
  endtask

  task automatic test_parity();
`ifdef SIMPLE_ARB_PARITY_CHK_EN
    ENERR_PARITY = 1'b1; waddr_flip = 1'b1;
    WADDR_VALID = 1'b1; WDATA_VALID = 1'b1; WADDR_DATA = 32'h60; WDATA_DATA = 64'h66;
    #1;
    n_checks++;
    if (WADDR_READY !== 1'b1) begin
      n_fail++; $display("FAIL par_wr_accept: wready %b want 1", WADDR_READY);
    end
    step();
    WADDR_VALID = 1'b0; WDATA_VALID = 1'b0; waddr_flip = 1'b0;
    n_checks++;
    if (MEM_REQ !== 1'b0 || ERR_PARITY !== 1'b1 || ERR_PARITY_B !== 1'b0 || STATUS !== exp_status) begin
      n_fail++; $display("FAIL par_wr_drop: req %b err %b err_b %b status %h want 0 1 0 %h",
        MEM_REQ, ERR_PARITY, ERR_PARITY_B, STATUS, exp_status);
    end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    n_checks++;
    if (ERR_PARITY !== 1'b0 || ERR_PARITY_B !== 1'b1) begin
      n_fail++; $display("FAIL par_clr: err %b err_b %b want 0 1", ERR_PARITY, ERR_PARITY_B);
    end
    FIERR_PARITY = 1'b1; RADDR_VALID = 1'b1; RADDR_DATA = 32'h10;
    step();
    FIERR_PARITY = 1'b0; RADDR_VALID = 1'b0;
    n_checks++;
    if (RDATA_VALID !== 1'b1 || RDATA_DATA !== 64'h0 || MEM_REQ !== 1'b0 || ERR_PARITY !== 1'b1) begin
      n_fail++; $display("FAIL par_fierr_rd: rvalid %b rdata %h req %b err %b want 1 0 0 1",
        RDATA_VALID, RDATA_DATA, MEM_REQ, ERR_PARITY);
    end
    RDATA_READY = 1'b1;
    step();
    RDATA_READY = 1'b0; ENERR_PARITY = 1'b0;
    n_checks++;
    if (RDATA_VALID !== 1'b0 || STATUS !== exp_status) begin
      n_fail++; $display("FAIL par_rd_done: rvalid %b status %h want 0 %h", RDATA_VALID, STATUS, exp_status);
    end
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
`else
    ENERR_PARITY = 1'b1; FIERR_PARITY = 1'b1; waddr_flip = 1'b1;
    WADDR_VALID = 1'b1; WDATA_VALID = 1'b1; WADDR_DATA = 32'h60; WDATA_DATA = 64'h66;
    step();
    WADDR_VALID = 1'b0; WDATA_VALID = 1'b0;
    n_checks++;
    if (MEM_REQ !== 1'b1 || ERR_PARITY !== 1'b0 || ERR_PARITY_B !== 1'b1) begin
      n_fail++; $display("FAIL nopar_wr: req %b err %b err_b %b want 1 0 1", MEM_REQ, ERR_PARITY, ERR_PARITY_B);
    end
    step();
    ENERR_PARITY = 1'b0; FIERR_PARITY = 1'b0; waddr_flip = 1'b0;
    exp_status = exp_status + 8'd1;
    n_checks++;
    if (STATUS !== exp_status || ERR_PARITY !== 1'b0) begin
      n_fail++; $display("FAIL nopar_status: status %h err %b want %h 0", STATUS, ERR_PARITY, exp_status);
    end
`endif
  endtask

  task automatic test_reset_mid();
    RADDR_VALID = 1'b1; RADDR_DATA = 32'h10; RDATA_READY = 1'b0;
    step();
    RADDR_VALID = 1'b0;
    step();
    RESETN_ACLK = 1'b0;
    step();
    RESETN_ACLK = 1'b1;
    exp_status = 8'h00;
    n_checks++;
    if (RDATA_VALID !== 1'b0 || STATUS !== 8'h00 || MEM_REQ !== 1'b0 || RDATA_DATA !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid: rvalid %b status %h req %b rdata %h want 0 00 0 0",
        RDATA_VALID, STATUS, MEM_REQ, RDATA_DATA);
    end
    step(); step(); step();
    n_checks++;
    if (RDATA_VALID !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_dropped: rvalid %b want 0", RDATA_VALID);
    end
  endtask

  task automatic test_wrap();
    WADDR_VALID = 1'b1; WDATA_VALID = 1'b1; WADDR_DATA = 32'h50; WDATA_DATA = 64'h5;
    for (int i = 0; i < 510; i++) step();
    WADDR_VALID = 1'b0; WDATA_VALID = 1'b0;
    exp_status = 8'hFF;
    n_checks++;
    if (STATUS !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_ff: status %h want ff", STATUS);
    end
    test_write(32'h51, 64'h51);
    n_checks++;
    if (STATUS !== 8'h00) begin
      n_fail++; $display("FAIL wrap_00: status %h want 00", STATUS);
    end
  endtask

  initial begin
    @(negedge ACLK);
    test_reset();
    test_write(32'h10, 64'hA5A5);
    test_write(32'h20, 64'h1234);
    test_read(32'h20, 64'h1234, 3);
    test_read(32'h10, 64'hA5A5, 1);
    test_alternate();
    test_wr_incomplete();
    test_parity();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
